// File: rtl/intc_pkg.sv
// Shared definitions for the intr_ctl interrupt controller: register offsets,
// FSM state encoding and the "no source" INTNUM code.
package intc_pkg;

    localparam logic [2:0] OFF_PEND = 3'd0;
    localparam logic [2:0] OFF_MASK = 3'd2;
    localparam logic [2:0] OFF_INSV = 3'd4;
    localparam logic [2:0] OFF_EOI  = 3'd6;

    localparam logic [3:0] INTNUM_NONE = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } intc_state_t;

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-first priority encoder: bit 0 is the highest priority.
module intc_prio_enc
    import intc_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] vec,
    output logic         valid,
    output logic [3:0]   idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                valid = 1'b1;
                idx   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/intr_ctl.sv
// Memory-mapped interrupt controller: synchronised edge capture, mask, in-service
// tracking and a registered request/number pair. Define INTC_NEST_EN for nesting.
module intr_ctl
    import intc_pkg::*;
#(
    parameter int               ABITS = 16,
    parameter int               DBITS = 16,
    parameter int               NSRC  = 3,
    parameter logic [ABITS-1:0] RBASE = 16'hFFD0
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [ABITS-1:0] ABUS,
    inout  tri   [DBITS-1:0] RBUS,
    input  logic             RE,
    input  logic [DBITS-1:0] WBUS,
    input  logic             WE,
    input  logic [NSRC-1:0]  IRQ,
    input  logic             INTACK,
    output logic             INTREQ,
    output logic [3:0]       INTNUM,
    output logic [1:0]       state_dbg
);

    intc_state_t      state, state_next;
    logic [3:0]       intnum, intnum_next;
    logic [NSRC-1:0]  sync1, sync2, sync3, irq_rise;
    logic [NSRC-1:0]  pend, mask, insv;
    logic [NSRC-1:0]  elig_raw, nest_allow, elig;
    logic [NSRC-1:0]  ack_set, eoi_clr, w1c;
    logic             e_valid, insv_valid, ack;
    logic [3:0]       e_idx, insv_idx;
    logic             in_blk, wr_pend, wr_mask, wr_eoi, rd_sel;
    logic [DBITS-1:0] rdata;
    logic             wbus_unused;

    assign in_blk  = (ABUS[ABITS-1:3] == RBASE[ABITS-1:3]);
    assign wr_pend = WE && in_blk && (ABUS[2:0] == OFF_PEND);
    assign wr_mask = WE && in_blk && (ABUS[2:0] == OFF_MASK);
    assign wr_eoi  = WE && in_blk && (ABUS[2:0] == OFF_EOI);
    assign rd_sel  = RE && in_blk;
    assign wbus_unused = ^WBUS[DBITS-1:NSRC];

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= IRQ;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign irq_rise = sync2 & ~sync3;
    assign elig_raw = pend & mask & ~insv;

    // With nesting, only sources above the top in-service entry may interrupt.
    always_comb begin
        nest_allow = '0;
        for (int i = 0; i < NSRC; i++) begin
`ifdef INTC_NEST_EN
            nest_allow[i] = !insv_valid || (4'(i) < insv_idx);
`else
            nest_allow[i] = !insv_valid;
`endif
        end
    end

    assign elig = elig_raw & nest_allow;

    intc_prio_enc #(.N(NSRC)) u_elig_enc (
        .vec   (elig),
        .valid (e_valid),
        .idx   (e_idx)
    );

    intc_prio_enc #(.N(NSRC)) u_insv_enc (
        .vec   (insv),
        .valid (insv_valid),
        .idx   (insv_idx)
    );

    // INTREQ/INTACK handshake: INTREQ holds until INTACK is seen while it is high;
    // INTACK with INTREQ low is dropped; before the ack the request may be
    // retracted or renumbered to a higher-priority source.
    assign ack = INTACK && (state == REQ);

    always_comb begin
        ack_set = '0;
        eoi_clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            ack_set[i] = ack && (intnum == 4'(i + 1));
            eoi_clr[i] = wr_eoi && insv_valid && (insv_idx == 4'(i));
        end
    end

    assign w1c = wr_pend ? WBUS[NSRC-1:0] : '0;

    // A fresh edge wins over a same-cycle W1C; an EOI pops before an ack pushes.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            pend <= '0;
            mask <= '0;
            insv <= '0;
        end else begin
            pend <= (pend & ~w1c & ~ack_set) | irq_rise;
            insv <= (insv & ~eoi_clr) | ack_set;
            if (wr_mask) begin
                mask <= WBUS[NSRC-1:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state  <= IDLE;
            intnum <= INTNUM_NONE;
        end else begin
            state  <= state_next;
            intnum <= intnum_next;
        end
    end

    always_comb begin
        state_next  = state;
        intnum_next = intnum;
        case (state)
            IDLE: begin
                if (e_valid) begin
                    state_next  = REQ;
                    intnum_next = e_idx + 4'd1;
                end
            end
            REQ: begin
                if (ack) begin
                    state_next  = SERV;
                    intnum_next = INTNUM_NONE;
                end else if (!e_valid) begin
                    state_next  = insv_valid ? SERV : IDLE;
                    intnum_next = INTNUM_NONE;
                end else begin
                    intnum_next = e_idx + 4'd1;
                end
            end
            SERV: begin
                if (e_valid) begin
                    state_next  = REQ;
                    intnum_next = e_idx + 4'd1;
                end else if (!insv_valid) begin
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next  = IDLE;
                intnum_next = INTNUM_NONE;
            end
        endcase
    end

    assign INTREQ    = (state == REQ);
    assign INTNUM    = intnum;
    assign state_dbg = state;

    always_comb begin
        rdata = '0;
        case (ABUS[2:0])
            OFF_PEND: rdata[NSRC-1:0] = pend;
            OFF_MASK: rdata[NSRC-1:0] = mask;
            OFF_INSV: rdata[NSRC-1:0] = insv;
            OFF_EOI:  rdata[3:0]      = intnum;
            default:  rdata           = '0;
        endcase
    end

    assign RBUS = rd_sel ? rdata : {DBITS{1'bz}};

endmodule

// File: tb/tb_intr_ctl.sv
// Directed bench for intr_ctl: a per-cycle vector table plus an asynchronous
// reset sequence taken while a request is outstanding.
module tb_intr_ctl;
    import intc_pkg::*;

    localparam logic [15:0] RBASE = 16'hFFD0;
    localparam int OP_N  = 0;
    localparam int OP_W  = 1;
    localparam int OP_R  = 2;
    localparam int OP_RW = 3;
    localparam int NN    = 15;
`ifdef INTC_NEST_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    typedef struct {
        logic [2:0]  irq;
        logic        ack;
        logic [1:0]  op;
        logic [3:0]  off;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic        exp_req;
        logic [3:0]  exp_num;
        logic [1:0]  exp_st;
    } vec_t;

    vec_t tbl[$];

    logic        clk, rst_n, re, we, intack, intreq;
    logic [15:0] abus, wbus;
    tri   [15:0] rbus;
    logic [2:0]  irq;
    logic [3:0]  intnum;
    logic [1:0]  state_dbg;
    int          n_cmp, n_err;

    intr_ctl dut (
        .CLK       (clk),
        .RESETN    (rst_n),
        .ABUS      (abus),
        .RBUS      (rbus),
        .RE        (re),
        .WBUS      (wbus),
        .WE        (we),
        .IRQ       (irq),
        .INTACK    (intack),
        .INTREQ    (intreq),
        .INTNUM    (intnum),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input int irq_v, input int ack_v, input int op_v,
                                input int off_v, input int wd, input int rd,
                                input int req_v, input int num_v, input int st_v);
        vec_t v;
        v.irq     = 3'(irq_v);
        v.ack     = 1'(ack_v);
        v.op      = 2'(op_v);
        v.off     = 4'(off_v);
        v.wdata   = 16'(wd);
        v.exp_rd  = 16'(rd);
        v.exp_req = 1'(req_v);
        v.exp_num = 4'(num_v);
        v.exp_st  = 2'(st_v);
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input int row,
                         input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge and check the outputs
    // left by the previous rising edge (and the combinational read, if any).
    task automatic apply(input vec_t v, input int row);
        @(negedge clk);
        irq    = v.irq;
        intack = v.ack;
        abus   = RBASE + {12'd0, v.off};
        wbus   = v.wdata;
        we     = (v.op == 2'(OP_W)) || (v.op == 2'(OP_RW));
        re     = (v.op == 2'(OP_R)) || (v.op == 2'(OP_RW));
        #1;
        check("intreq", row, 16'(intreq), 16'(v.exp_req));
        check("intnum", row, 16'(intnum), 16'(v.exp_num));
        check("state", row, 16'(state_dbg), 16'(v.exp_st));
        if (re) check("rbus", row, rbus, v.exp_rd);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; re = 1'b0; we = 1'b0; intack = 1'b0;
        irq = '0; abus = RBASE; wbus = '0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_intreq", -1, 16'(intreq), 16'd0);
        check("rst_intnum", -1, 16'(intnum), 16'h000F);
        check("rst_state", -1, 16'(state_dbg), 16'(IDLE));
        re = 1'b1;
        abus = RBASE + 16'd2; #1;
        check("rst_mask", -1, rbus, 16'h0000);
        abus = RBASE + 16'd6; #1;
        check("rst_eoi_rd", -1, rbus, 16'h000F);
        re = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // single source: pulse on IRQ[0], ack, EOI
        add(0,0,OP_W,2,1, 0, 0,NN,IDLE);
        add(1,0,OP_N,0,0, 0, 0,NN,IDLE);
        add(0,0,OP_N,0,0, 0, 0,NN,IDLE);
        add(0,0,OP_N,0,0, 0, 0,NN,IDLE);
        add(0,0,OP_R,0,0, 1, 0,NN,IDLE);
        add(0,1,OP_N,0,0, 0, 1,1,REQ);
        add(0,0,OP_R,4,0, 1, 0,NN,SERV);
        add(0,0,OP_R,0,0, 0, 0,NN,SERV);
        add(0,0,OP_W,6,0, 0, 0,NN,SERV);
        add(0,0,OP_R,4,0, 0, 0,NN,SERV);
        add(0,0,OP_R,6,0, 15, 0,NN,IDLE);
        // IRQ[1] and IRQ[2] together: priority order, EOI hands over next cycle
        add(6,0,OP_W,2,7, 0, 0,NN,IDLE);
        add(6,0,OP_N,0,0, 0, 0,NN,IDLE);
        add(6,0,OP_N,0,0, 0, 0,NN,IDLE);
        add(6,0,OP_N,0,0, 0, 0,NN,IDLE);
        add(6,1,OP_N,0,0, 0, 1,2,REQ);
        add(6,0,OP_W,6,0, 0, 0,NN,SERV);
        add(6,0,OP_N,0,0, 0, 0,NN,SERV);
        add(6,1,OP_N,0,0, 0, 1,3,REQ);
        add(6,0,OP_W,6,0, 0, 0,NN,SERV);
        add(6,0,OP_N,0,0, 0, 0,NN,SERV);
        add(6,0,OP_R,6,0, 15, 0,NN,IDLE);
        // masked pending source, unmask, then retract before ack
        add(0,0,OP_W,2,0, 0, 0,NN,IDLE);
        add(4,0,OP_N,0,0, 0, 0,NN,IDLE);
        add(4,0,OP_N,0,0, 0, 0,NN,IDLE);
        add(4,0,OP_N,0,0, 0, 0,NN,IDLE);
        add(4,0,OP_R,0,0, 4, 0,NN,IDLE);
        add(4,0,OP_W,2,4, 0, 0,NN,IDLE);
        add(4,0,OP_N,0,0, 0, 0,NN,IDLE);
        add(4,0,OP_W,2,0, 0, 1,3,REQ);
        add(4,0,OP_N,0,0, 0, 1,3,REQ);
        add(4,0,OP_R,0,0, 4, 0,NN,IDLE);
        // W1C alone clears; W1C colliding with a new edge leaves the bit set
        add(6,0,OP_N,0,0, 0, 0,NN,IDLE);
        add(6,0,OP_N,0,0, 0, 0,NN,IDLE);
        add(6,0,OP_N,0,0, 0, 0,NN,IDLE);
        add(4,0,OP_N,0,0, 0, 0,NN,IDLE);
        add(6,0,OP_R,0,0, 6, 0,NN,IDLE);
        add(6,0,OP_W,0,4, 0, 0,NN,IDLE);
        add(6,0,OP_RW,0,2, 2, 0,NN,IDLE);
        add(6,0,OP_R,0,0, 2, 0,NN,IDLE);
        add(0,0,OP_W,0,7, 0, 0,NN,IDLE);
        // upper MASK bits read 0, stray ack ignored, out-of-block write ignored
        add(0,1,OP_W,2,16'hFFFF, 0, 0,NN,IDLE);
        add(0,0,OP_R,2,0, 7, 0,NN,IDLE);
        add(0,0,OP_W,10,0, 0, 0,NN,IDLE);
        add(0,0,OP_R,2,0, 7, 0,NN,IDLE);
        add(0,0,OP_W,2,0, 0, 0,NN,IDLE);
        add(0,0,OP_R,4,0, 0, 0,NN,IDLE);
        // source 3 in service, then IRQ[0] rises (nesting-dependent)
        add(4,0,OP_W,2,7, 0, 0,NN,IDLE);
        add(4,0,OP_N,0,0, 0, 0,NN,IDLE);
        add(4,0,OP_N,0,0, 0, 0,NN,IDLE);
        add(4,0,OP_N,0,0, 0, 0,NN,IDLE);
        add(4,1,OP_N,0,0, 0, 1,3,REQ);
        add(5,0,OP_N,0,0, 0, 0,NN,SERV);
        add(5,0,OP_N,0,0, 0, 0,NN,SERV);
        add(5,0,OP_N,0,0, 0, 0,NN,SERV);
        add(5,0,OP_N,0,0, 0, 0,NN,SERV);
        add(5,1,OP_N,0,0, 0, NEST ? 1 : 0, NEST ? 1 : NN, NEST ? REQ : SERV);
        add(5,0,OP_R,4,0, NEST ? 5 : 4, 0,NN,SERV);
        add(5,0,OP_W,6,0, 0, 0,NN,SERV);
        add(5,0,OP_R,4,0, NEST ? 4 : 0, 0,NN,SERV);
        add(5, NEST ? 0 : 1, NEST ? OP_W : OP_N, 6,0, 0,
            NEST ? 0 : 1, NEST ? NN : 1, NEST ? SERV : REQ);
        add(5,0, NEST ? OP_R : OP_W, NEST ? 4 : 6, 0, 0, 0,NN,SERV);
        add(5,0,OP_N,0,0, 0, 0,NN, NEST ? IDLE : SERV);
        add(5,0,OP_R,4,0, 0, 0,NN,IDLE);
        // bring IRQ[1] to REQ for the reset sequence
        add(7,0,OP_N,0,0, 0, 0,NN,IDLE);
        add(7,0,OP_N,0,0, 0, 0,NN,IDLE);
        add(7,0,OP_N,0,0, 0, 0,NN,IDLE);
        add(7,0,OP_N,0,0, 0, 0,NN,IDLE);
        add(7,0,OP_N,0,0, 0, 1,2,REQ);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // asynchronous reset between clock edges while INTREQ is high
        we = 1'b0; re = 1'b0; intack = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_intreq", -2, 16'(intreq), 16'd0);
        check("arst_intnum", -2, 16'(intnum), 16'h000F);
        check("arst_state", -2, 16'(state_dbg), 16'(IDLE));
        re = 1'b1;
        abus = RBASE + 16'd2;
        #1;
        check("arst_mask", -2, rbus, 16'h0000);
        re = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
